// File: rtl/apb2axi_issue_ctrl.sv
// Issue controller: pops committed directory entries in order and routes
// them to the write or read request FIFO under per-direction credits.
module apb2axi_issue_ctrl #(
   parameter int ENTRY_W      = 64,
   parameter int TAG_W        = 4,
   parameter int MAX_WR_OUT   = 4,
   parameter int MAX_RD_OUT   = 4,
   parameter int STRICT_ORDER = 0,
   parameter int CNT_W        = 4
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               pend_valid,
   input  logic [ENTRY_W-1:0] pend_entry,
   input  logic               pend_is_write,
   input  logic [TAG_W-1:0]   pend_tag,
   output logic               pend_pop,
   output logic               wr_push_valid,
   input  logic               wr_push_ready,
   output logic [ENTRY_W-1:0] wr_push_data,
   output logic               rd_push_valid,
   input  logic               rd_push_ready,
   output logic [ENTRY_W-1:0] rd_push_data,
   output logic [TAG_W-1:0]   issue_tag,
   input  logic               wr_cpl,
   input  logic               rd_cpl,
   output logic [CNT_W-1:0]   wr_outstanding,
   output logic [CNT_W-1:0]   rd_outstanding,
   output logic               cpl_err,
   output logic               busy
);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   localparam logic [CNT_W-1:0] WR_MAX = CNT_W'(MAX_WR_OUT);
   localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(MAX_RD_OUT);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t             state_q;
   state_t             state_d;
   logic [ENTRY_W-1:0] hold_entry_q;
   logic [TAG_W-1:0]   hold_tag_q;
   logic               hold_wr_q;
   logic               last_wr_q;
   logic [CNT_W-1:0]   wr_cnt_q;
   logic [CNT_W-1:0]   rd_cnt_q;
   logic               cpl_err_q;

   logic push_fire;
   logic has_credit;
   logic fence_ok;
   logic wr_inc;
   logic wr_dec;
   logic rd_inc;
   logic rd_dec;

   assign push_fire = (state_q == HOLD) &&
                      (hold_wr_q ? wr_push_ready : rd_push_ready);

   // Credit and fence use registered counts only; a same-cycle
   // completion never frees a slot early.
   always_comb begin
      has_credit = 1'b0;
      fence_ok   = 1'b1;
      if (pend_is_write) begin
         has_credit = (wr_cnt_q < WR_MAX);
      end else begin
         has_credit = (rd_cnt_q < RD_MAX);
      end
      if (STRICT_ORDER != 0) begin
         fence_ok = (pend_is_write == last_wr_q) ||
                    (pend_is_write ? (rd_cnt_q == '0)
                                   : (wr_cnt_q == '0));
      end
   end

   always_comb begin
      state_d  = state_q;
      pend_pop = 1'b0;
      unique case (state_q)
         IDLE: begin
            pend_pop = pend_valid && has_credit && fence_ok;
            if (pend_pop) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            pend_pop = push_fire && pend_valid &&
                       has_credit && fence_ok;
            if (push_fire && !pend_pop) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         hold_entry_q <= '0;
         hold_tag_q   <= '0;
         hold_wr_q    <= 1'b0;
         last_wr_q    <= 1'b1;
      end else if (pend_pop) begin
         hold_entry_q <= pend_entry;
         hold_tag_q   <= pend_tag;
         hold_wr_q    <= pend_is_write;
         last_wr_q    <= pend_is_write;
      end
   end

   assign wr_inc = pend_pop && pend_is_write;
   assign rd_inc = pend_pop && !pend_is_write;
   assign wr_dec = wr_cpl && (wr_cnt_q != '0);
   assign rd_dec = rd_cpl && (rd_cnt_q != '0);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_cnt_q <= '0;
      end else if (wr_inc && !wr_dec) begin
         wr_cnt_q <= wr_cnt_q + ONE;
      end else if (!wr_inc && wr_dec) begin
         wr_cnt_q <= wr_cnt_q - ONE;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_cnt_q <= '0;
      end else if (rd_inc && !rd_dec) begin
         rd_cnt_q <= rd_cnt_q + ONE;
      end else if (!rd_inc && rd_dec) begin
         rd_cnt_q <= rd_cnt_q - ONE;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cpl_err_q <= 1'b0;
      end else if ((wr_cpl && wr_cnt_q == '0) ||
                   (rd_cpl && rd_cnt_q == '0)) begin
         cpl_err_q <= 1'b1;
      end
   end

   assign wr_push_valid  = (state_q == HOLD) && hold_wr_q;
   assign rd_push_valid  = (state_q == HOLD) && !hold_wr_q;
   assign wr_push_data   = hold_entry_q;
   assign rd_push_data   = hold_entry_q;
   assign issue_tag      = hold_tag_q;
   assign wr_outstanding = wr_cnt_q;
   assign rd_outstanding = rd_cnt_q;
   assign cpl_err        = cpl_err_q;
   assign busy           = (state_q == HOLD) ||
                           (wr_cnt_q != '0) || (rd_cnt_q != '0);

endmodule
